dpcm_saturator: RTL and testbench
=================================

Name: dpcm_saturator

Overview:
Parametrised clamp stage for the DPCM datapath. Each accepted sample is limited to [MIN_VAL, MAX_VAL], in unsigned or two's-complement mode. Results go into an output FIFO of DEPTH entries with full valid/ready handshake on both sides, so the stage tolerates downstream backpressure without dropping samples. It sits between the predictor/quantiser output and the encoder.

Parameters:
WIDTH, 8, sample width in bits (>=2)
SIGNED_MODE, 0, 0 = unsigned compare, 1 = two's-complement compare
MAX_VAL, 200, upper clamp bound, interpreted per SIGNED_MODE
MIN_VAL, 0, lower clamp bound, interpreted per SIGNED_MODE; must be <= MAX_VAL
DEPTH, 4, output FIFO entries, power of two >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  WIDTH  upstream sample
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_data  out  WIDTH  clamped sample at FIFO head
out_sat  out  1  head sample was clamped (1) or passed unchanged (0)
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs and state clear immediately on rst assertion, with no clock edge required. in_ready=0 while rst is high. After rst deasserts, in_ready=1 from the first clk edge. out_valid=0, out_data=0, out_sat=0, fifo_level=0. Pointers and counters are 0. FIFO contents are don't-care.
- Push: occurs when in_valid && in_ready at a rising clk edge. The clamp is computed combinationally on in_data and written, together with its sat flag, into the FIFO tail in the same edge.
- Clamp rule: if data > MAX_VAL then MAX_VAL, sat=1. Else if data < MIN_VAL then MIN_VAL, sat=1. Else data, sat=0. Compares are $signed when SIGNED_MODE=1, otherwise unsigned. The value equal to either bound passes with sat=0.
- Pop: occurs when out_valid && out_ready at a rising edge. The head advances.
- Latency: a sample pushed at edge N is visible on out_data/out_valid after edge N if the FIFO was empty. No combinational path from in_* to out_*.
- in_ready = (fifo_level != DEPTH). It is combinational from registered state only and never depends on out_ready. A pop on a full FIFO does not permit a same-cycle push.
- Simultaneous push and pop on a non-full, non-empty FIFO: fifo_level is unchanged and both transfers complete.
- Empty FIFO: out_valid=0. out_data/out_sat hold their last popped values (registered head). A pop request is ignored.
- Full FIFO: in_valid is ignored. No overwrite. The upstream must hold its data (standard valid/ready stability).
- Pointer wrap: the read/write pointers are $clog2(DEPTH) bits plus one wrap bit. Full/empty are decoded from the wrap-bit mismatch.
- Reset mid-operation: the FIFO is flushed and in-flight samples are discarded. out_valid falls asynchronously.
- out_valid/out_data must stay stable while out_valid && !out_ready.

Optional Feature:
Macro: DPCM_SAT_STATS_EN.
- Defined: adds outputs sat_hi_cnt (16 bits) and sat_lo_cnt (16 bits), plus input stats_clr (1 bit).
  - The counters increment on each push clamped to MAX_VAL / MIN_VAL respectively.
  - The counters saturate at 16'hFFFF and do not wrap.
  - stats_clr zeroes both counters synchronously. If stats_clr coincides with a push, the clear wins.
  - The counters reset to 0 on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=8, unsigned, MAX=200, MIN=0: push 250, 200, 100 with out_ready=1 -> out_data 200/sat=1, 200/sat=0, 100/sat=0. Each appears the cycle after its push.
- SIGNED_MODE=1, MAX=100, MIN=-100: push 8'h80 (-128), 8'h7F (127), 8'hF6 (-10) -> 8'h9C sat=1, 8'h64 sat=1, 8'hF6 sat=0.
- DEPTH=4, out_ready=0: push 5 samples back-to-back -> in_ready drops after the 4th push and fifo_level=4. The 5th sample is held by the source. Raising out_ready drains the samples in order, and the 5th is accepted the cycle after in_ready returns.
- Continuous in_valid and out_ready=1 for 20 cycles -> one sample per cycle, fifo_level constant at 1, no loss or reorder across pointer wrap.
- Fill with 3 samples, then assert rst mid-cycle for 1 cycle -> out_valid=0 and fifo_level=0 immediately. After release, the first new sample emerges with no stale data.
- DPCM_SAT_STATS_EN: push 70000 values of 255 (MAX=200) -> sat_hi_cnt=16'hFFFF, sat_lo_cnt=0. Pulse stats_clr -> both counters read 0 next cycle.

Source files
------------

// File: rtl/dpcm_saturator.sv
// Clamp stage for the DPCM datapath: limits each sample to [MIN_VAL, MAX_VAL] and queues it in an output FIFO.
// Optional saturation statistics are enabled with the DPCM_SAT_STATS_EN macro.
module dpcm_saturator #(
   parameter int WIDTH       = 8,
   parameter int SIGNED_MODE = 0,
   parameter int MAX_VAL     = 200,
   parameter int MIN_VAL     = 0,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_sat,
   output logic [$clog2(DEPTH):0] fifo_level
`ifdef DPCM_SAT_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [15:0]            sat_hi_cnt,
   output logic [15:0]            sat_lo_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam bit SM = (SIGNED_MODE != 0);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
   // Both modes compare in one extra bit so a single signed compare covers unsigned data too.
   localparam logic signed [WIDTH:0] MAX_E = {(SM ? MAX_V[WIDTH-1] : 1'b0), MAX_V};
   localparam logic signed [WIDTH:0] MIN_E = {(SM ? MIN_V[WIDTH-1] : 1'b0), MIN_V};

   logic signed [WIDTH:0] d_ext;
   logic                  above;
   logic                  below;
   logic [WIDTH-1:0]      clamp_data;
   logic                  clamp_sat;

   always_comb begin
      d_ext      = {(SM ? in_data[WIDTH-1] : 1'b0), in_data};
      above      = (d_ext > MAX_E);
      below      = (d_ext < MIN_E);
      clamp_data = in_data;
      if (above) begin
         clamp_data = MAX_V;
      end else if (below) begin
         clamp_data = MIN_V;
      end
      clamp_sat  = above | below;
   end

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH:0]   mem [DEPTH];
   logic             run;
   logic [WIDTH-1:0] last_data;
   logic             last_sat;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid and data hold until then.
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty      = (wr_ptr == rd_ptr);
   assign fifo_level = wr_ptr - rd_ptr;
   assign in_ready   = run && !full;
   assign out_valid  = !empty;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;

   // When empty the head shows the last popped entry, which is zero after reset.
   always_comb begin
      {out_sat, out_data} = {last_sat, last_data};
      if (!empty) begin
         {out_sat, out_data} = mem[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         run       <= 1'b0;
         last_data <= '0;
         last_sat  <= 1'b0;
      end else begin
         run <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr                <= rd_ptr + 1'b1;
            {last_sat, last_data} <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {clamp_sat, clamp_data};
      end
   end

`ifdef DPCM_SAT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_hi_cnt <= '0;
         sat_lo_cnt <= '0;
      end else if (stats_clr) begin
         sat_hi_cnt <= '0;
         sat_lo_cnt <= '0;
      end else begin
         if (push && above && (sat_hi_cnt != 16'hFFFF)) begin
            sat_hi_cnt <= sat_hi_cnt + 16'd1;
         end
         if (push && below && (sat_lo_cnt != 16'hFFFF)) begin
            sat_lo_cnt <= sat_lo_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dpcm_saturator.sv
// Bench for dpcm_saturator: unsigned instance checked against a queue model every cycle, plus a signed instance.
module tb_dpcm_saturator;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sat;
   logic [2:0] fifo_level;

   logic       s_in_valid;
   logic       s_in_ready;
   logic [7:0] s_in_data;
   logic       s_out_valid;
   logic       s_out_ready;
   logic [7:0] s_out_data;
   logic       s_out_sat;
   logic [2:0] s_fifo_level;

`ifdef DPCM_SAT_STATS_EN
   logic        stats_clr;
   logic [15:0] sat_hi_cnt;
   logic [15:0] sat_lo_cnt;
   logic        s_stats_clr;
   logic [15:0] s_sat_hi_cnt;
   logic [15:0] s_sat_lo_cnt;
`endif

   int checks;
   int failures;

   dpcm_saturator #(.WIDTH(8), .SIGNED_MODE(0), .MAX_VAL(200), .MIN_VAL(0), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .fifo_level(fifo_level)
`ifdef DPCM_SAT_STATS_EN
      , .stats_clr(stats_clr), .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt)
`endif
   );

   dpcm_saturator #(.WIDTH(8), .SIGNED_MODE(1), .MAX_VAL(100), .MIN_VAL(-100), .DEPTH(DEPTH)) u_sgn (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_sat(s_out_sat),
      .fifo_level(s_fifo_level)
`ifdef DPCM_SAT_STATS_EN
      , .stats_clr(s_stats_clr), .sat_hi_cnt(s_sat_hi_cnt), .sat_lo_cnt(s_sat_lo_cnt)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] model_clamp(input logic [7:0] d, input bit sgn, input int mx, input int mn);
      int v;
      v = sgn ? int'($signed(d)) : int'(d);
      if (v > mx) return {1'b1, 8'(mx)};
      if (v < mn) return {1'b1, 8'(mn)};
      return {1'b0, d};
   endfunction

   // ---------------- reference model (unsigned instance) ----------------
   logic [8:0] exp_q[$];
   bit         m_run;
   logic [8:0] m_last;

   initial begin
      m_run  = 1'b0;
      m_last = '0;
   end

   always @(posedge clk or posedge rst) begin : model
      bit acc_in;
      bit acc_out;
      if (rst) begin
         exp_q.delete();
         m_run  = 1'b0;
         m_last = '0;
      end else begin
         acc_in  = in_valid && m_run && (exp_q.size() != DEPTH);
         acc_out = out_ready && (exp_q.size() != 0);
         if (acc_out) m_last = exp_q.pop_front();
         if (acc_in) exp_q.push_back(model_clamp(in_data, 1'b0, 200, 0));
         m_run = 1'b1;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("fifo_level", fifo_level, exp_q.size());
      chk("in_ready", in_ready, m_run && (exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
         chk("out_data", out_data, exp_q[0][7:0]);
         chk("out_sat", out_sat, exp_q[0][8]);
      end else begin
         chk("hold_data", out_data, m_last[7:0]);
         chk("hold_sat", out_sat, m_last[8]);
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic [7:0] v);
      bit acc;
      in_valid = 1'b1;
      in_data  = v;
      for (int t = 0; t < 50; t++) begin
         acc = in_ready;
         @(negedge clk);
         if (acc) return;
      end
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept value=%0h", v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      s_in_valid  = 1'b0;
      s_in_data   = '0;
      s_out_ready = 1'b1;
`ifdef DPCM_SAT_STATS_EN
      stats_clr   = 1'b0;
      s_stats_clr = 1'b0;
`endif
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_level", fifo_level, 0);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);

      // unsigned clamp, one cycle latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'd250;
      @(negedge clk);
      chk("u250_data", out_data, 8'd200);
      chk("u250_sat", out_sat, 1);
      in_data = 8'd200;
      @(negedge clk);
      chk("u200_data", out_data, 8'd200);
      chk("u200_sat", out_sat, 0);
      in_data = 8'd100;
      @(negedge clk);
      chk("u100_data", out_data, 8'd100);
      chk("u100_sat", out_sat, 0);
      in_valid = 1'b0;
      @(negedge clk);

      // signed clamp on the second instance
      s_in_valid = 1'b1;
      s_in_data  = 8'h80;
      @(negedge clk);
      chk("s80_data", s_out_data, 8'h9C);
      chk("s80_sat", s_out_sat, 1);
      s_in_data = 8'h7F;
      @(negedge clk);
      chk("s7f_data", s_out_data, 8'h64);
      chk("s7f_sat", s_out_sat, 1);
      s_in_data = 8'hF6;
      @(negedge clk);
      chk("sf6_data", s_out_data, 8'hF6);
      chk("sf6_sat", s_out_sat, 0);
      s_in_valid = 1'b0;
      @(negedge clk);

      // backpressure: fill, hold the fifth, then drain
      out_ready = 1'b0;
      send(8'd10);
      send(8'd220);
      send(8'd30);
      send(8'd40);
      chk("full_level", fifo_level, 4);
      chk("full_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'd55;
      @(negedge clk);
      chk("held_level", fifo_level, 4);
      chk("held_ready", in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("pop_full_level", fifo_level, 3);
      chk("pop_full_ready", in_ready, 1);
      @(negedge clk);
      chk("fifth_in_level", fifo_level, 3);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("drained_level", fifo_level, 0);

      // streaming across pointer wrap
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i * 29 + 3);
         @(negedge clk);
         chk("stream_level", fifo_level, 1);
      end
      in_valid = 1'b0;
      @(negedge clk);

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send(8'd7);
      send(8'd250);
      send(8'd9);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_level", fifo_level, 0);
      chk("arst_in_ready", in_ready, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      send(8'd77);
      chk("post_rst_data", out_data, 8'd77);
      chk("post_rst_sat", out_sat, 0);
      in_valid = 1'b0;
      @(negedge clk);

`ifdef DPCM_SAT_STATS_EN
      chk("stats_start_hi", sat_hi_cnt, 0);
      in_valid = 1'b1;
      in_data  = 8'd255;
      repeat (65534) @(negedge clk);
      chk("stats_hi_fffe", sat_hi_cnt, 16'hFFFE);
      repeat (70000 - 65534) @(negedge clk);
      chk("stats_hi_sat", sat_hi_cnt, 16'hFFFF);
      chk("stats_lo", sat_lo_cnt, 0);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      in_valid  = 1'b0;
      chk("stats_clr_hi", sat_hi_cnt, 0);
      chk("stats_clr_lo", sat_lo_cnt, 0);
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
